// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction kinds, opcode map and helpers used by
// both the boot loader encoder and the pipeline decoder.
package cpu_pkg;

  typedef enum logic [3:0] {
    KIND_RTYPE = 4'd0,
    KIND_JR    = 4'd1,
    KIND_ADDI  = 4'd2,
    KIND_SLTI  = 4'd3,
    KIND_ORI   = 4'd4,
    KIND_LUI   = 4'd5,
    KIND_LW    = 4'd6,
    KIND_SW    = 4'd7,
    KIND_BEQ   = 4'd8,
    KIND_BNE   = 4'd9,
    KIND_BGT   = 4'd10,
    KIND_BGEZ  = 4'd11,
    KIND_J     = 4'd12,
    KIND_JAL   = 4'd13,
    KIND_ILL14 = 4'd14,
    KIND_ILL15 = 4'd15
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BGEZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  // BGEZ shares opcode 1 with the REGIMM group; rt=1 selects it.
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  function automatic logic [31:0] itype(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational symbolic-instruction encoder: kind plus fields to a 32-bit
// MIPS word; illegal kinds yield a NOP and raise the illegal flag.
module instr_encoder
  import cpu_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_kind_t'(kind))
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_JR:    word = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
      KIND_ADDI:  word = itype(OP_ADDI, rs, rt, imm);
      KIND_SLTI:  word = itype(OP_SLTI, rs, rt, imm);
      KIND_ORI:   word = itype(OP_ORI, rs, rt, imm);
      KIND_LUI:   word = itype(OP_LUI, 5'd0, rt, imm);
      KIND_LW:    word = itype(OP_LW, rs, rt, imm);
      KIND_SW:    word = itype(OP_SW, rs, rt, imm);
      KIND_BEQ:   word = itype(OP_BEQ, rs, rt, imm);
      KIND_BNE:   word = itype(OP_BNE, rs, rt, imm);
      KIND_BGT:   word = itype(OP_BGT, rs, rt, imm);
      KIND_BGEZ:  word = itype(OP_BGEZ, rs, RT_BGEZ, imm);
      KIND_J:     word = {OP_J, target};
      // The CPU forms the $31 link itself, so JAL carries only the target.
      KIND_JAL:   word = {OP_JAL, target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction-memory writer: accepts symbolic requests, encodes them
// and writes consecutive words while holding the CPU until the image is done.
module instr_loader
  import cpu_pkg::*;
#(
  parameter  int IM_DEPTH = 128,
  localparam int CW       = $clog2(IM_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [3:0]    req_kind_i,
  input  logic [4:0]    req_rs_i,
  input  logic [4:0]    req_rt_i,
  input  logic [4:0]    req_rd_i,
  input  logic [4:0]    req_shamt_i,
  input  logic [5:0]    req_funct_i,
  input  logic [15:0]   req_imm_i,
  input  logic [25:0]   req_target_i,
  input  logic          req_last_i,
  output logic          im_we_o,
  output logic [31:0]   im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic          cpu_hold_o,
  output logic [CW-1:0] count_o,
  output logic          done_o,
  output logic          err_o
);

  load_state_t state_reg;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;
  logic        last_slot;

  instr_encoder u_encoder (
    .kind    (req_kind_i),
    .rs      (req_rs_i),
    .rt      (req_rt_i),
    .rd      (req_rd_i),
    .shamt   (req_shamt_i),
    .funct   (req_funct_i),
    .imm     (req_imm_i),
    .target  (req_target_i),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept    = req_valid_i && req_ready_o;
  assign last_slot = (count_o == CW'(IM_DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      req_ready_o <= 1'b0;
      im_we_o     <= 1'b0;
      im_addr_o   <= '0;
      im_wdata_o  <= '0;
      cpu_hold_o  <= 1'b1;
      count_o     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      im_we_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg   <= ST_LOAD;
            req_ready_o <= 1'b1;
            cpu_hold_o  <= 1'b1;
            count_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            im_we_o    <= 1'b1;
            im_addr_o  <= {30'(count_o), 2'b00};
            im_wdata_o <= enc_word;
            count_o    <= count_o + 1'b1;
            if (enc_illegal) err_o <= 1'b1;
            if (req_last_i) begin
              req_ready_o <= 1'b0;
            end else if (last_slot) begin
              req_ready_o <= 1'b0;
              err_o       <= 1'b1;
            end
          // Ready only drops once the session is ending; leave as the final
          // word's write strobe retires.
          end else if (!req_ready_o && im_we_o) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state_reg   <= ST_LOAD;
            req_ready_o <= 1'b1;
            cpu_hold_o  <= 1'b1;
            count_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
          end else begin
            done_o     <= 1'b1;
            cpu_hold_o <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a full-size instance for the encoding and
// session tests, and a 4-word instance for the overflow and restart cases.
module tb_instr_loader;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start_m, start_s, valid_m, valid_s;
  logic [3:0] kind;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic last;

  logic ready_m, we_m, hold_m, done_m, err_m;
  logic [31:0] addr_m, data_m;
  logic [7:0] count_m;
  logic ready_s, we_s, hold_s, done_s, err_s;
  logic [31:0] addr_s, data_s;
  logic [2:0] count_s;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_m[$], exp_s[$], obs_m[$], obs_s[$];
  int checks = 0;
  int errors = 0;
  int idx_m = 0;
  int idx_s = 0;
  int cyc = 0;

  instr_loader #(.IM_DEPTH(128)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_m), .req_valid_i(valid_m),
    .req_ready_o(ready_m), .req_kind_i(kind), .req_rs_i(rs), .req_rt_i(rt),
    .req_rd_i(rd), .req_shamt_i(shamt), .req_funct_i(funct), .req_imm_i(imm),
    .req_target_i(target), .req_last_i(last), .im_we_o(we_m), .im_addr_o(addr_m),
    .im_wdata_o(data_m), .cpu_hold_o(hold_m), .count_o(count_m), .done_o(done_m),
    .err_o(err_m)
  );

  instr_loader #(.IM_DEPTH(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .req_valid_i(valid_s),
    .req_ready_o(ready_s), .req_kind_i(kind), .req_rs_i(rs), .req_rt_i(rt),
    .req_rd_i(rd), .req_shamt_i(shamt), .req_funct_i(funct), .req_imm_i(imm),
    .req_target_i(target), .req_last_i(last), .im_we_o(we_s), .im_addr_o(addr_s),
    .im_wdata_o(data_s), .cpu_hold_o(hold_s), .count_o(count_s), .done_o(done_s),
    .err_o(err_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    if (we_m) begin
      w.addr = addr_m; w.data = data_m; w.cyc = cyc;
      obs_m.push_back(w);
    end
    if (we_s) begin
      w.addr = addr_s; w.data = data_s; w.cyc = cyc;
      obs_s.push_back(w);
    end
  end

  task automatic send(input bit sel, input logic [3:0] k, input logic [4:0] a_rs,
                      input logic [4:0] a_rt, input logic [4:0] a_rd, input logic [4:0] a_sh,
                      input logic [5:0] a_fn, input logic [15:0] a_imm,
                      input logic [25:0] a_tg, input logic a_last, input logic [31:0] word);
    int budget;
    wr_t w;
    int got;
    kind = k; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh; funct = a_fn;
    imm = a_imm; target = a_tg; last = a_last;
    if (sel) valid_s = 1'b1; else valid_m = 1'b1;
    budget = 0;
    while (!(sel ? ready_s : ready_m) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) begin
      checks++; errors++;
      $display("FAIL accept_timeout sel=%0d word=%08h never accepted", sel, word);
      valid_m = 1'b0; valid_s = 1'b0;
      return;
    end
    @(posedge clk);
    w.data = word; w.cyc = 0;
    if (sel) begin
      w.addr = 32'(idx_s * 4); exp_s.push_back(w); idx_s++;
    end else begin
      w.addr = 32'(idx_m * 4); exp_m.push_back(w); idx_m++;
    end
    @(negedge clk);
    got = sel ? int'(count_s) : int'(count_m);
    checks++;
    if (got != (sel ? idx_s : idx_m)) begin
      errors++;
      $display("FAIL count sel=%0d got %0d expected %0d", sel, got, sel ? idx_s : idx_m);
    end
  endtask

  task automatic idle_req();
    valid_m = 1'b0; valid_s = 1'b0; last = 1'b0;
  endtask

  task automatic do_start(input bit sel);
    @(negedge clk);
    if (sel) start_s = 1'b1; else start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0; start_s = 1'b0;
    if (sel) idx_s = 0; else idx_m = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready_m, we_m, hold_m, done_m, err_m} !== 5'b00100 || addr_m !== 0 || data_m !== 0 || count_m !== 0) begin
      errors++;
      $display("FAIL reset_main got rdy/we/hold/done/err=%b addr=%h data=%h cnt=%0d expected 00100/0/0/0",
               {ready_m, we_m, hold_m, done_m, err_m}, addr_m, data_m, count_m);
    end
    checks++;
    if ({ready_s, we_s, hold_s, done_s, err_s} !== 5'b00100 || addr_s !== 0 || data_s !== 0 || count_s !== 0) begin
      errors++;
      $display("FAIL reset_small got rdy/we/hold/done/err=%b addr=%h data=%h cnt=%0d expected 00100/0/0/0",
               {ready_s, we_s, hold_s, done_s, err_s}, addr_s, data_s, count_s);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_m !== 1'b0 || hold_m !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_start got ready=%b hold=%b expected 0 1", ready_m, hold_m);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    int prev;
    do_start(0);
    checks++;
    if (ready_m !== 1'b1 || hold_m !== 1'b1 || done_m !== 1'b0) begin
      errors++;
      $display("FAIL start_load got ready=%b hold=%b done=%b expected 1 1 0", ready_m, hold_m, done_m);
    end
    send(0, KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0, 32'h20010005);
    send(0, KIND_LW, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0, 32'h8C220004);
    start_m = 1'b1;
    send(0, KIND_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 32'h00221820);
    start_m = 1'b0;
    send(0, KIND_JR, 5'd31, 5'd5, 5'd7, 5'd3, 6'h21, 16'hABCD, 26'h155, 1'b0, 32'h03E00008);
    idle_req();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    prev = -1;
    while (exp_m.size() > 0) begin
      e = exp_m.pop_front();
      checks++;
      if (obs_m.size() == 0) begin
        errors++;
        $display("FAIL b2b_write_missing expected %08h @%08h", e.data, e.addr);
      end else begin
        o = obs_m.pop_front();
        if (o.addr !== e.addr || o.data !== e.data || (prev >= 0 && o.cyc != prev + 1)) begin
          errors++;
          $display("FAIL b2b_write got %08h @%08h cyc %0d expected %08h @%08h cyc %0d",
                   o.data, o.addr, o.cyc, e.data, e.addr, prev + 1);
        end
        prev = o.cyc;
      end
    end
    checks++;
    if (obs_m.size() != 0) begin
      errors++;
      $display("FAIL b2b_unexpected got %0d extra writes expected 0", obs_m.size());
      obs_m.delete();
    end
  endtask

  task automatic test_illegal();
    wr_t e, o;
    send(0, KIND_ILL15, 5'd9, 5'd9, 5'd9, 5'd9, 6'd9, 16'h9999, 26'h999, 1'b0, 32'h00000000);
    checks++;
    if (err_m !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b expected 1", err_m);
    end
    send(0, KIND_LUI, 5'd7, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 32'h3C031234);
    send(0, KIND_SLTI, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 32'h2843FFFF);
    idle_req();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    checks++;
    if (err_m !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b expected 1", err_m);
    end
    while (exp_m.size() > 0) begin
      e = exp_m.pop_front();
      checks++;
      if (obs_m.size() == 0) begin
        errors++;
        $display("FAIL ill_write_missing expected %08h @%08h", e.data, e.addr);
      end else begin
        o = obs_m.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL ill_write got %08h @%08h expected %08h @%08h", o.data, o.addr, e.data, e.addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    kind = KIND_BEQ; rs = 5'd1; rt = 5'd2; imm = 16'd8; last = 1'b0;
    valid_m = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid_m = 1'b0;
    checks++;
    if ({ready_m, we_m, hold_m, done_m, err_m} !== 5'b00100 || addr_m !== 0 || data_m !== 0 || count_m !== 0) begin
      errors++;
      $display("FAIL reset_mid got rdy/we/hold/done/err=%b addr=%h data=%h cnt=%0d expected 00100/0/0/0",
               {ready_m, we_m, hold_m, done_m, err_m}, addr_m, data_m, count_m);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    checks++;
    if (obs_m.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_strobe got %0d writes expected 0", obs_m.size());
      obs_m.delete();
    end
    idx_m = 0;
    idx_s = 0;
  endtask

  task automatic test_last();
    wr_t e, o;
    do_start(0);
    send(0, KIND_BGEZ, 5'd4, 5'd9, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 1'b0, 32'h04810003);
    send(0, KIND_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1, 32'h0C000010);
    idle_req();
    checks++;
    if (ready_m !== 1'b0) begin
      errors++;
      $display("FAIL last_ready got %b expected 0", ready_m);
    end
    @(negedge clk);
    checks++;
    if (done_m !== 1'b0 || hold_m !== 1'b1) begin
      errors++;
      $display("FAIL last_done_early got done=%b hold=%b expected 0 1", done_m, hold_m);
    end
    @(negedge clk);
    checks++;
    if (done_m !== 1'b1 || hold_m !== 1'b0 || count_m !== 8'd2) begin
      errors++;
      $display("FAIL last_done got done=%b hold=%b cnt=%0d expected 1 0 2", done_m, hold_m, count_m);
    end
    @(posedge clk); #2;
    while (exp_m.size() > 0) begin
      e = exp_m.pop_front();
      checks++;
      if (obs_m.size() == 0) begin
        errors++;
        $display("FAIL last_write_missing expected %08h @%08h", e.data, e.addr);
      end else begin
        o = obs_m.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL last_write got %08h @%08h expected %08h @%08h", o.data, o.addr, e.data, e.addr);
        end
      end
    end
  endtask

  task automatic test_overflow();
    wr_t e, o;
    do_start(1);
    for (int i = 1; i <= 4; i++)
      send(1, KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0, 32'h20010000 | 32'(i));
    checks++;
    if (ready_s !== 1'b0 || err_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ready got ready=%b err=%b expected 0 1", ready_s, err_s);
    end
    kind = KIND_ORI; rs = 5'd1; rt = 5'd1; imm = 16'hFFFF;
    valid_s = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (count_s !== 3'd4 || done_s !== 1'b1 || ready_s !== 1'b0 || err_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done got cnt=%0d done=%b ready=%b err=%b expected 4 1 0 1",
               count_s, done_s, ready_s, err_s);
    end
    idle_req();
    @(posedge clk); #2;
    while (exp_s.size() > 0) begin
      e = exp_s.pop_front();
      checks++;
      if (obs_s.size() == 0) begin
        errors++;
        $display("FAIL ovf_write_missing expected %08h @%08h", e.data, e.addr);
      end else begin
        o = obs_s.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL ovf_write got %08h @%08h expected %08h @%08h", o.data, o.addr, e.data, e.addr);
        end
      end
    end
    checks++;
    if (obs_s.size() != 0) begin
      errors++;
      $display("FAIL ovf_extra_write got %0d extra writes expected 0", obs_s.size());
      obs_s.delete();
    end
  endtask

  task automatic test_restart();
    wr_t e, o;
    do_start(1);
    checks++;
    if (err_s !== 1'b0 || done_s !== 1'b0 || hold_s !== 1'b1 || count_s !== 3'd0 || ready_s !== 1'b1) begin
      errors++;
      $display("FAIL restart got err=%b done=%b hold=%b cnt=%0d ready=%b expected 0 0 1 0 1",
               err_s, done_s, hold_s, count_s, ready_s);
    end
    send(1, KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0, 32'h20010007);
    send(1, KIND_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF);
    idle_req();
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    checks++;
    if (done_s !== 1'b1 || err_s !== 1'b0) begin
      errors++;
      $display("FAIL restart_done got done=%b err=%b expected 1 0", done_s, err_s);
    end
    while (exp_s.size() > 0) begin
      e = exp_s.pop_front();
      checks++;
      if (obs_s.size() == 0) begin
        errors++;
        $display("FAIL restart_write_missing expected %08h @%08h", e.data, e.addr);
      end else begin
        o = obs_s.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL restart_write got %08h @%08h expected %08h @%08h", o.data, o.addr, e.data, e.addr);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_m = 1'b0; start_s = 1'b0; valid_m = 1'b0; valid_s = 1'b0;
    kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    imm = '0; target = '0; last = 1'b0;
    test_reset();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_last();
    test_overflow();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction-memory writer for the pipelined CPU: accepts symbolic instruction requests over a valid/ready handshake, encodes each into a 32-bit MIPS word using the CPU's opcode map, and writes the words into instruction memory at consecutive addresses. It holds the CPU in stall until the program is fully written, so the pipeline's IF/ID decode path only ever sees a completely loaded image.

## Interface
- IM_DEPTH, 128, instruction memory size in words; counter width is clog2(IM_DEPTH)+1
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous and active-high
- start_i  in  1  begin a load session; honoured in IDLE and DONE
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&&ready at a rising edge
- req_kind_i  in  4  instruction class (package enum)
- req_rs_i / req_rt_i / req_rd_i / req_shamt_i  in  5 each  register and shift fields
- req_funct_i  in  6  R-type funct
- req_imm_i  in  16  immediate / branch offset
- req_target_i  in  26  jump target
- req_last_i  in  1  marks the final instruction of the program
- im_we_o  out  1  instruction-memory write strobe
- im_addr_o  out  32  byte address, always 4*word index
- im_wdata_o  out  32  encoded instruction
- cpu_hold_o  out  1  stall/hold for the CPU
- count_o  out  clog2(IM_DEPTH)+1  words written this session
- done_o  out  1  load session complete
- err_o  out  1  sticky error: illegal kind or overflow

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: ready=0, hold=1. start_i -> LOAD, count cleared, err cleared.
- LOAD: ready=1 while count < IM_DEPTH. Each accepted request is encoded and registered into a single write stage; count increments at acceptance.
- Encoding (op/fields): RTYPE op 0, rs/rt/rd/shamt/funct from inputs; JR op 0, rs, funct 8, other fields 0; ADDI 8, SLTI 10, ORI 13, LW 35, SW 43: op|rs|rt|imm; LUI 15: rs=0; BEQ 4, BNE 5, BGT 7: op|rs|rt|offset; BGEZ op 1, rt=1; J op 2, JAL op 3: op|target. JAL writes no link field; the CPU forms $31 itself.
- Kinds 14–15 are illegal: the slot is still consumed, 0x00000000 (NOP) is written, err_o is set.
- Accepting a request with req_last_i=1 -> DONE after that word's write cycle.
- If count reaches IM_DEPTH without req_last_i: ready drops, err_o is set, and the FSM enters DONE once the pending write drains.
- DONE: done=1, hold=0, ready=0. start_i restarts the session: LOAD, count=0, err=0, hold=1, and memory is overwritten from address 0.
- start_i in LOAD is ignored.

## Timing
- Reset values: state IDLE, req_ready_o 0, im_we_o 0, im_addr_o 0, im_wdata_o 0, cpu_hold_o 1, count_o 0, done_o 0, err_o 0. Reset mid-session discards any pending write; no strobe issues in the cycle after reset.
- Latency: request accepted at edge N -> im_we_o high for exactly one cycle, N to N+1, with addr/data valid the whole cycle.
- Throughput: one word per cycle with no bubbles.
- Last word: im_we_o for the last word is high in cycle N+1; done_o rises and cpu_hold_o falls at edge N+2.
- Overflow: ready is low in the cycle after the IM_DEPTH-th acceptance. A valid request held at that point is never accepted.
- count_o updates at the acceptance edge, before the corresponding write.

## Structure
- Shared package (cpu_pkg): instruction-kind enum, 6-bit opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_BGT, OP_BGEZ, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_J, OP_JAL), and FUNCT_JR. The decoder uses the same constants, so the encoding and decoding sides cannot drift apart.
- Sub-module: instr_encoder, purely combinational (kind + fields -> 32-bit word + illegal flag).
- instr_loader contains the FSM, counter, and write register.

## Test plan
- ADDI rs=0 rt=1 imm=5, then LW rs=1 rt=2 imm=4 back-to-back -> writes 0x20010005 @0x0 and 0x8C220004 @0x4 on consecutive cycles.
- RTYPE rs=1 rt=2 rd=3 funct=0x20; JR rs=31 -> 0x00221820 and 0x03E00008.
- BGEZ rs=4 imm=3; JAL target=0x10 with last=1 -> 0x04810003 and 0x0C000010. done_o and hold deassertion occur 2 edges after the last accept; count_o=2.
- Kind 15 mid-stream -> 0x00000000 is written at its slot and err_o=1 stays sticky; later words land at the following addresses.
- IM_DEPTH=4, 5 requests with no last -> 4 writes; ready low after the 4th; err_o=1; DONE reached; 5th request never accepted.
- Assert rst_i during LOAD with a pending write -> no im_we_o, all outputs at reset values. start_i from DONE restarts at address 0 with err cleared.
